riscv_v_elem_sequencer: RTL and testbench
=========================================

RISCV_V_ELEM_SEQUENCER -- requirements
Module: riscv_v_elem_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register length in bits.
REQ-002 SHALL have parameter DATAPATH_W, default 64: bits processed per beat; power of two, 64..VLEN; BPB = DATAPATH_W/8 bytes per beat.
REQ-003 SHALL have parameter MAX_LMUL, default 8: maximum register-group multiplier. Derived: VLMAX_B = VLEN*MAX_LMUL/8, VL_W = $clog2(VLMAX_B)+1, BEAT_W = $clog2(VLMAX_B/BPB).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-006 clear_pipe  in  1  pipeline flush; aborts the current operation.
REQ-007 issue_valid  in  1  new vector op offered.
REQ-008 issue_ready  out  1  sequencer accepts the op this cycle.
REQ-009 issue_vl  in  VL_W  element count vl.
REQ-010 issue_vstart  in  VL_W  first element index vstart.
REQ-011 issue_sew  in  2  vsew encoding; 0/1/2/3 = 8/16/32/64 bit.
REQ-012 issue_mask  in  VLMAX_B  v0 mask, one bit per element; used only under REQ-030.
REQ-013 beat_valid  out  1  beat descriptor valid.
REQ-014 beat_ready  in  1  execute datapath consumes the beat.
REQ-015 beat_idx  out  BEAT_W  DATAPATH_W-chunk index within the register group.
REQ-016 beat_byte_en  out  BPB  per-byte write enable for the beat.
REQ-017 beat_first / beat_last  out  1 each  first / final beat of the op.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM IDLE, RUN, DONE; issue_ready = (state==IDLE) && !clear_pipe.
REQ-021 On an issue handshake SHALL register vl, vstart, sew and mask; if vstart >= vl, go to DONE with no beats; else go to RUN with beat_idx = (vstart<<sew)/BPB.
REQ-022 In RUN, beat_valid SHALL be 1. On beat_valid && beat_ready: if beat_last, go to DONE; else increment beat_idx.
REQ-023 beat_last SHALL be 1 iff (beat_idx+1)*BPB >= (vl<<sew). beat_first SHALL be 1 on the first beat after issue only.
REQ-024 Byte b of beat k SHALL be enabled iff e = (k*BPB+b)>>sew satisfies vstart <= e < vl.
REQ-025 All beat outputs SHALL derive from registered state only (no combinational path from beat_ready), and SHALL hold stable while beat_valid && !beat_ready.
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE; the earliest next issue is the following cycle.
REQ-027 clear_pipe in any state SHALL force IDLE next cycle; done SHALL NOT pulse for the aborted op. rst takes priority over clear_pipe.
REQ-028 Arithmetic SHALL be unsigned at VL_W+3 bits; no wrap at vl = VLMAX_B with sew = 3.

Reset
REQ-029 With rst = 0 at a clock edge, the block SHALL reset as follows: state = IDLE, beat_idx = 0, all latched fields = 0; outputs issue_ready = 0 during reset, beat_valid = 0, done = 0, busy = 0, beat_byte_en = 0, beat_first = 0, beat_last = 0. Reset applied mid-RUN SHALL abandon the op with no done pulse.

Configuration
REQ-030 Macro RISCV_V_SEQ_MASK_EN. When defined, beat_byte_en SHALL additionally require mask bit e = 1. When undefined, issue_mask SHALL be ignored, no mask storage SHALL be built, and REQ-024 applies alone. A fully masked beat is still issued, with beat_byte_en = 0.

Verification
REQ-031 DATAPATH_W=64, sew=1, vl=10, vstart=3 -> 3 beats: idx0 en=0xC0 first; idx1 en=0xFF; idx2 en=0x0F last; done pulses one cycle after the idx2 handshake.
REQ-032 vl=5, vstart=5 -> no beat_valid; done pulses the cycle after issue; busy is high for 1 cycle.
REQ-033 Same op as REQ-031 with beat_ready low for 3 cycles on idx1 -> idx1 and en=0xFF held stable; total 3 handshakes.
REQ-034 clear_pipe during idx1 of REQ-031 -> IDLE next cycle, no done, issue_ready = 1 one cycle later.
REQ-035 MASK_EN, sew=0, vl=8, vstart=0, mask=0xA5 -> single beat, en=0xA5, first=last=1.
REQ-036 rst low mid-RUN -> all outputs at reset values the next cycle; a new issue after reset behaves per REQ-031.

Source files
------------

// File: rtl/riscv_v_elem_sequencer.sv
// Vector element sequencer: walks an op's register group in DATAPATH_W beats with byte enables.
// Optional v0 masking of byte enables is built when RISCV_V_SEQ_MASK_EN is defined.
module riscv_v_elem_sequencer #(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned DATAPATH_W = 64,
  parameter int unsigned MAX_LMUL   = 8,
  localparam int unsigned BPB       = DATAPATH_W / 8,
  localparam int unsigned VLMAX_B   = VLEN * MAX_LMUL / 8,
  localparam int unsigned VL_W      = $clog2(VLMAX_B) + 1,
  localparam int unsigned BEAT_W    = $clog2(VLMAX_B / BPB)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_pipe,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [VL_W-1:0]      issue_vl,
  input  logic [VL_W-1:0]      issue_vstart,
  input  logic [1:0]           issue_sew,
  input  logic [VLMAX_B-1:0]   issue_mask,
  output logic                 beat_valid,
  input  logic                 beat_ready,
  output logic [BEAT_W-1:0]    beat_idx,
  output logic [BPB-1:0]       beat_byte_en,
  output logic                 beat_first,
  output logic                 beat_last,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned AW     = VL_W + 3;
  localparam int unsigned BPB_SH = $clog2(BPB);
  localparam int unsigned EIDX_W = $clog2(VLMAX_B);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [VL_W-1:0] vl_q, vstart_q;
  logic [1:0]      sew_q;
  // Beat counter is wider than beat_idx so that sew=3 groups terminate without wrapping.
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            load;

  logic [AW-1:0]   vl_bytes;
  logic [AW-1:0]   start_cnt;
  logic            last;
  logic [BPB-1:0]  en;

`ifdef RISCV_V_SEQ_MASK_EN
  logic [VLMAX_B-1:0] mask_q;
`else
  logic unused_mask;
  assign unused_mask = ^issue_mask;
`endif

  always_comb begin
    vl_bytes  = AW'(vl_q) << sew_q;
    start_cnt = (AW'(issue_vstart) << issue_sew) >> BPB_SH;
    last      = ((cnt_q + AW'(1)) << BPB_SH) >= vl_bytes;
  end

  always_comb begin
    en = '0;
    for (int b = 0; b < BPB; b++) begin
      logic [AW-1:0] addr;
      logic [AW-1:0] elem;
      addr  = (cnt_q << BPB_SH) + AW'(b);
      elem  = addr >> sew_q;
      en[b] = (elem >= AW'(vstart_q)) && (elem < AW'(vl_q));
`ifdef RISCV_V_SEQ_MASK_EN
      en[b] = en[b] && mask_q[elem[EIDX_W-1:0]];
`endif
    end
  end

  // Beat outputs come from registered state only, so they hold while stalled.
  always_comb begin
    issue_ready  = (state_q == StIdle) && !clear_pipe && rst;
    beat_valid   = (state_q == StRun);
    beat_idx     = cnt_q[BEAT_W-1:0];
    beat_byte_en = beat_valid ? en : '0;
    beat_first   = beat_valid && first_q;
    beat_last    = beat_valid && last;
    done         = (state_q == StDone);
    busy         = (state_q != StIdle);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue_valid && issue_ready) begin
          load = 1'b1;
          if (issue_vstart >= issue_vl) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            state_d = StRun;
            cnt_d   = start_cnt;
            first_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (beat_ready) begin
          first_d = 1'b0;
          if (last) state_d = StDone;
          else      cnt_d   = cnt_q + AW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_pipe) begin
      state_d = StIdle;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      vl_q     <= '0;
      vstart_q <= '0;
      sew_q    <= '0;
`ifdef RISCV_V_SEQ_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      if (load) begin
        vl_q     <= issue_vl;
        vstart_q <= issue_vstart;
        sew_q    <= issue_sew;
`ifdef RISCV_V_SEQ_MASK_EN
        mask_q   <= issue_mask;
`endif
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_elem_sequencer.sv
// Bench for riscv_v_elem_sequencer: element-level reference model, per-cycle beat scoreboard,
// plus directed vectors with literal expectations.
module tb_riscv_v_elem_sequencer;

  localparam int BPB     = 8;
  localparam int VLMAX_B = 128;
`ifdef RISCV_V_SEQ_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  typedef struct {
    int         idx;
    logic [7:0] en;
    bit         first;
    bit         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst, clear_pipe, issue_valid, beat_ready;
  logic [7:0]   issue_vl, issue_vstart;
  logic [1:0]   issue_sew;
  logic [127:0] issue_mask;
  logic         issue_ready, beat_valid, beat_first, beat_last, done, busy;
  logic [3:0]   beat_idx;
  logic [7:0]   beat_byte_en;

  riscv_v_elem_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .clear_pipe   (clear_pipe),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_vl     (issue_vl),
    .issue_vstart (issue_vstart),
    .issue_sew    (issue_sew),
    .issue_mask   (issue_mask),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_idx     (beat_idx),
    .beat_byte_en (beat_byte_en),
    .beat_first   (beat_first),
    .beat_last    (beat_last),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    pending = 0;
  int    exp_done_cyc = -1;
  int    hs_count = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$];
  beat_t mq[$];
  beat_t h_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element-centric reference: mark every byte of every active element, then slice into beats.
  function automatic void model_build(input int vl, input int vs, input int sew,
                                      input logic [127:0] m);
    logic [1023:0] byt;
    int k0, k1;
    beat_t b;
    byt = '0;
    mq.delete();
    for (int e = vs; e < vl; e++)
      if (!MaskEn || m[e])
        for (int j = 0; j < (1 << sew); j++) byt[(e << sew) + j] = 1'b1;
    if (vs >= vl) return;
    k0 = (vs << sew) / BPB;
    k1 = ((vl << sew) + BPB - 1) / BPB - 1;
    for (int k = k0; k <= k1; k++) begin
      b.idx   = k % 16;
      b.en    = byt[k*BPB +: 8];
      b.first = (k == k0);
      b.last  = (k == k1);
      mq.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (beat_valid) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          h_mon = exp_q[0];
          check("beat_idx", beat_idx, h_mon.idx);
          check("beat_byte_en", beat_byte_en, h_mon.en);
          check("beat_first_last", {beat_first, beat_last}, {h_mon.first, h_mon.last});
          if (beat_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            if (h_mon.last) exp_done_cyc = cyc + 1;
          end
        end
      end
      if (done || cyc == exp_done_cyc) begin
        check("done_pulse", {done, cyc == exp_done_cyc, pending > 0}, 3'b111);
        if (done && pending > 0) pending--;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the handshake edge.
  task automatic do_issue(input int vl, input int vs, input int sew, input logic [127:0] m);
    issue_valid  = 1'b1;
    issue_vl     = 8'(vl);
    issue_vstart = 8'(vs);
    issue_sew    = 2'(sew);
    issue_mask   = m;
    @(negedge clk);
    check("issue_ready", issue_ready, 1);
    model_build(vl, vs, sew, m);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    pending++;
    if (vs >= vl) exp_done_cyc = cyc + 1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (pending > 0 && n < budget) begin
      step();
      beat_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
      n++;
    end
    check(name, (pending == 0) && (exp_q.size() == 0), 1);
  endtask

  task automatic flush_model;
    exp_q.delete();
    pending      = 0;
    exp_done_cyc = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, bc, bv, dc;
    rst = 1'b0; clear_pipe = 1'b0; issue_valid = 1'b0; beat_ready = 1'b0;
    issue_vl = '0; issue_vstart = '0; issue_sew = '0; issue_mask = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_issue_ready", issue_ready, 0);
    check("rst_ctrl_outs", {beat_valid, done, busy, beat_first, beat_last}, 0);
    check("rst_byte_en", beat_byte_en, 0);
    check("rst_beat_idx", beat_idx, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("issue_ready_after_rst", issue_ready, 1);
    step();

    // Pin the model against hand-computed vectors.
    model_build(10, 3, 1, '0);
    check("model_031_n", mq.size(), 3);
    check("model_031_en", {mq[0].en, mq[1].en, mq[2].en}, 24'hC0FF0F);
    check("model_031_idx", {4'(mq[0].idx), 4'(mq[2].idx)}, 8'h02);
    check("model_031_fl", {mq[0].first, mq[0].last, mq[2].first, mq[2].last}, 4'b1001);
    model_build(7, 2, 2, '1);
    check("model_sew2", {8'(mq.size()), 8'(mq[0].idx), mq[2].en}, 24'h03010F);
    model_build(8, 0, 0, 128'hA5);
    check("model_mask", {8'(mq.size()), mq[0].en}, {8'd1, MaskEn ? 8'hA5 : 8'hFF});

    // Basic three-beat op with constant ready.
    beat_ready = 1'b1; rdy_mode = 0; hs0 = hs_count;
    do_issue(10, 3, 1, '0);
    wait_idle(50, "op031_complete");
    check("op031_handshakes", hs_count - hs0, 3);

    // vstart >= vl: no beats, one busy cycle.
    bc = 0; bv = 0;
    do_issue(5, 5, 0, '0);
    repeat (3) begin
      @(negedge clk);
      if (busy) bc++;
      if (beat_valid) bv++;
      step();
    end
    check("novl_busy_cycles", bc, 1);
    check("novl_beats", bv, 0);
    check("novl_done_seen", pending, 0);

    // Stall idx1 for three cycles.
    hs0 = hs_count;
    do_issue(10, 3, 1, '0);
    step();
    beat_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {beat_valid, beat_idx, beat_byte_en}, {1'b1, 4'd1, 8'hFF});
      step();
    end
    beat_ready = 1'b1;
    wait_idle(50, "op033_complete");
    check("op033_handshakes", hs_count - hs0, 3);

    // Flush during idx1.
    do_issue(10, 3, 1, '0);
    step();
    clear_pipe = 1'b1; beat_ready = 1'b0;
    step();
    clear_pipe = 1'b0;
    flush_model();
    @(negedge clk);
    check("clr_idle", {beat_valid, busy, done, issue_ready}, 4'b0001);
    dc = 0;
    repeat (5) begin
      step();
      @(negedge clk);
      if (done) dc++;
    end
    check("clr_no_done", dc, 0);
    step();

    // Reset mid-run, then the same op again.
    beat_ready = 1'b1;
    do_issue(10, 3, 1, '0);
    rst = 1'b0;
    step();
    flush_model();
    @(negedge clk);
    check("midrst_outs", {issue_ready, beat_valid, done, busy, beat_first, beat_last}, 0);
    check("midrst_en_idx", {beat_byte_en, beat_idx}, 0);
    step();
    rst = 1'b1;
    hs0 = hs_count;
    do_issue(10, 3, 1, '0);
    wait_idle(50, "op036_complete");
    check("op036_handshakes", hs_count - hs0, 3);

    // Single fully-enabled (or masked) byte beat.
    beat_ready = 1'b0;
    do_issue(8, 0, 0, 128'hA5);
    @(negedge clk);
    check("op035_beat", {beat_byte_en, beat_first, beat_last},
          {MaskEn ? 8'hA5 : 8'hFF, 2'b11});
    step();
    beat_ready = 1'b1;
    wait_idle(20, "op035_complete");

    // sew=2 with irregular ready, and mask affecting only the masked build.
    rdy_mode = 1;
    do_issue(7, 2, 2, 128'h55);
    wait_idle(50, "sew2_complete");

    // Full group at sew=3: 128 beats, beat_idx wraps, must still terminate.
    hs0 = hs_count;
    do_issue(VLMAX_B, 0, 3, {128{1'b1}});
    wait_idle(1000, "vlmax_sew3_complete");
    check("vlmax_sew3_handshakes", hs_count - hs0, 128);

    // Final element of a full sew=3 group alone, and vl=0.
    do_issue(VLMAX_B, VLMAX_B - 1, 3, {128{1'b1}});
    wait_idle(50, "last_elem_complete");
    do_issue(0, 0, 2, '0);
    wait_idle(10, "vl0_complete");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
